// File: rtl/pkt_filter_mc.sv
// Ingress classifier: steers each AXI-Stream packet to data out, control out (with channel) or drop.
// Optional statistics counters are enabled by defining PKT_FILTER_MC_STATS_EN.
module pkt_filter_mc #(
  parameter int DATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 128,
  parameter int NUM_CTRL_PORTS = 4,
  parameter logic [16*NUM_CTRL_PORTS-1:0] CTRL_PORTS = {16'hf4f1, 16'hf3f1, 16'hf2f1, 16'hf1f1},
  localparam int CW = (NUM_CTRL_PORTS > 1) ? $clog2(NUM_CTRL_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [95:0]              time_stamp,
  input  logic [31:0]              cookie_val,
  output logic [31:0]              ctrl_token,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic                     c_m_axis_tvalid,
  output logic                     c_m_axis_tlast,
  input  logic                     c_m_axis_tready,
  output logic [CW-1:0]            c_m_axis_chan,
  output logic [31:0]              stat_data_pkts,
  output logic [31:0]              stat_ctrl_pkts,
  output logic [31:0]              stat_drop_pkts,
  output logic [31:0]              stat_auth_fail
);

  typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTL, DROP} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]   m_dat_q, c_dat_q;
  logic [DATA_WIDTH/8-1:0] m_keep_q, c_keep_q;
  logic [TUSER_WIDTH-1:0]  m_user_q, c_user_q;
  logic                    m_vld_q, m_last_q, c_vld_q, c_last_q;
  logic [CW-1:0]           chan_q;
  logic [31:0]             token_q;

  logic          is_udp, hit_any, auth_ok;
  logic [CW-1:0] hit_idx;
  logic [31:0]   cookie, token;
  logic          dec_data, dec_ctrl, dec_auth_fail, dec_drop;
  logic          s_acc, first_acc, load_m, load_c;

  logic unused_ts;
  assign unused_ts = ^time_stamp[95:32];

  // Header fields are byte-reversed on the wire; reassemble them MSB-first.
  assign is_udp = (s_axis_tdata[143:128] == 16'h0008) && (s_axis_tdata[223:216] == 8'h11);
  assign cookie = {s_axis_tdata[399:392], s_axis_tdata[407:400],
                   s_axis_tdata[415:408], s_axis_tdata[423:416]};
  assign token  = {s_axis_tdata[431:424], s_axis_tdata[439:432],
                   s_axis_tdata[447:440], s_axis_tdata[455:448]};
  assign auth_ok = (cookie == cookie_val) && (token == token_q);

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CTRL_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tdata[335:320] == CTRL_PORTS[16*i +: 16]) begin
        hit_any = 1'b1;
        hit_idx = CW'(i);
      end
    end
  end

  assign dec_data      = is_udp && !hit_any;
  assign dec_ctrl      = is_udp && hit_any && auth_ok;
  assign dec_auth_fail = is_udp && hit_any && !auth_ok;
  assign dec_drop      = !is_udp || dec_auth_fail;

  assign s_axis_tready = aresetn && ((state_q == DROP) ||
                         ((!m_vld_q || m_axis_tready) && (!c_vld_q || c_m_axis_tready)));
  assign s_acc = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d   = state_q;
    first_acc = 1'b0;
    load_m    = 1'b0;
    load_c    = 1'b0;
    if (s_acc) begin
      case (state_q)
        IDLE: begin
          first_acc = 1'b1;
          if (dec_data) begin
            load_m = 1'b1;
            if (!s_axis_tlast) state_d = FWD_DATA;
          end else if (dec_ctrl) begin
            load_c = 1'b1;
            if (!s_axis_tlast) state_d = FWD_CTL;
          end else if (!s_axis_tlast) begin
            state_d = DROP;
          end
        end
        FWD_DATA: begin
          load_m = 1'b1;
          if (s_axis_tlast) state_d = IDLE;
        end
        FWD_CTL: begin
          load_c = 1'b1;
          if (s_axis_tlast) state_d = IDLE;
        end
        DROP:    if (s_axis_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      m_dat_q  <= '0;  m_keep_q <= '0;  m_user_q <= '0;  m_vld_q <= 1'b0;  m_last_q <= 1'b0;
      c_dat_q  <= '0;  c_keep_q <= '0;  c_user_q <= '0;  c_vld_q <= 1'b0;  c_last_q <= 1'b0;
      chan_q   <= '0;
      token_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (load_m) begin
        m_dat_q  <= s_axis_tdata;
        m_keep_q <= s_axis_tkeep;
        m_user_q <= s_axis_tuser;
        m_last_q <= s_axis_tlast;
        m_vld_q  <= 1'b1;
      end else if (m_axis_tready) begin
        m_vld_q <= 1'b0;
      end
      if (load_c) begin
        c_dat_q  <= s_axis_tdata;
        c_keep_q <= s_axis_tkeep;
        c_user_q <= s_axis_tuser;
        c_last_q <= s_axis_tlast;
        c_vld_q  <= 1'b1;
      end else if (c_m_axis_tready) begin
        c_vld_q <= 1'b0;
      end
      // A successful control packet consumes the token; the next one must use the new value.
      if (first_acc && dec_ctrl) begin
        chan_q  <= hit_idx;
        token_q <= time_stamp[31:0];
      end
    end
  end

  assign m_axis_tdata    = m_dat_q;
  assign m_axis_tkeep    = m_keep_q;
  assign m_axis_tuser    = m_user_q;
  assign m_axis_tvalid   = m_vld_q;
  assign m_axis_tlast    = m_last_q;
  assign c_m_axis_tdata  = c_dat_q;
  assign c_m_axis_tkeep  = c_keep_q;
  assign c_m_axis_tuser  = c_user_q;
  assign c_m_axis_tvalid = c_vld_q;
  assign c_m_axis_tlast  = c_last_q;
  assign c_m_axis_chan   = chan_q;
  assign ctrl_token      = token_q;

`ifdef PKT_FILTER_MC_STATS_EN
  logic [31:0] st_data_q, st_ctrl_q, st_drop_q, st_auth_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      st_data_q <= 32'h0;
      st_ctrl_q <= 32'h0;
      st_drop_q <= 32'h0;
      st_auth_q <= 32'h0;
    end else if (first_acc) begin
      if (dec_data)      st_data_q <= st_data_q + 32'd1;
      if (dec_ctrl)      st_ctrl_q <= st_ctrl_q + 32'd1;
      if (dec_drop)      st_drop_q <= st_drop_q + 32'd1;
      if (dec_auth_fail) st_auth_q <= st_auth_q + 32'd1;
    end
  end

  assign stat_data_pkts = st_data_q;
  assign stat_ctrl_pkts = st_ctrl_q;
  assign stat_drop_pkts = st_drop_q;
  assign stat_auth_fail = st_auth_q;
`else
  assign stat_data_pkts = 32'h0;
  assign stat_ctrl_pkts = 32'h0;
  assign stat_drop_pkts = 32'h0;
  assign stat_auth_fail = 32'h0;
`endif

endmodule

// File: tb/tb_pkt_filter_mc.sv
// Scoreboard bench for pkt_filter_mc: expected beats queued at input acceptance, popped at output handshake.
module tb_pkt_filter_mc;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [95:0]   time_stamp;
  logic [31:0]   cookie_val, ctrl_token;
  logic [511:0]  s_axis_tdata, m_axis_tdata, c_m_axis_tdata;
  logic [63:0]   s_axis_tkeep, m_axis_tkeep, c_m_axis_tkeep;
  logic [127:0]  s_axis_tuser, m_axis_tuser, c_m_axis_tuser;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tready;
  logic [1:0]    c_m_axis_chan;
  logic [31:0]   stat_data_pkts, stat_ctrl_pkts, stat_drop_pkts, stat_auth_fail;

  always #5 clk = ~clk;

  pkt_filter_mc dut (
    .clk(clk), .aresetn(aresetn), .time_stamp(time_stamp), .cookie_val(cookie_val),
    .ctrl_token(ctrl_token),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tuser(c_m_axis_tuser),
    .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast),
    .c_m_axis_tready(c_m_axis_tready), .c_m_axis_chan(c_m_axis_chan),
    .stat_data_pkts(stat_data_pkts), .stat_ctrl_pkts(stat_ctrl_pkts),
    .stat_drop_pkts(stat_drop_pkts), .stat_auth_fail(stat_auth_fail)
  );

  typedef struct {
    logic [511:0] d;
    logic [127:0] u;
    logic         l;
    logic [1:0]   ch;
  } exp_t;

  exp_t mq[$];
  exp_t cq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   e_data = 0, e_ctrl = 0, e_drop = 0, e_auth = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_hdr(input logic [15:0] ety, input logic [7:0] proto,
                                          input logic [15:0] port, input logic [31:0] ck,
                                          input logic [31:0] tk, input logic [15:0] id);
    logic [511:0] h;
    h = '0;
    h[15:0]    = id;
    h[143:128] = ety;
    h[223:216] = proto;
    h[335:320] = port;
    h[399:392] = ck[31:24]; h[407:400] = ck[23:16]; h[415:408] = ck[15:8]; h[423:416] = ck[7:0];
    h[431:424] = tk[31:24]; h[439:432] = tk[23:16]; h[447:440] = tk[15:8]; h[455:448] = tk[7:0];
    return h;
  endfunction

  function automatic logic [31:0] stat_exp(input int v);
`ifdef PKT_FILTER_MC_STATS_EN
    return 32'(v);
`else
    return (v == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "_st_data"}, stat_data_pkts, stat_exp(e_data));
    check({tag, "_st_ctrl"}, stat_ctrl_pkts, stat_exp(e_ctrl));
    check({tag, "_st_drop"}, stat_drop_pkts, stat_exp(e_drop));
    check({tag, "_st_auth"}, stat_auth_fail, stat_exp(e_auth));
  endtask

  // dest: 0 data, 1 control, 2 drop, 3 auth-fail drop. rdy_mode: 1 track readiness, 2 expect always ready.
  task automatic send_pkt(input logic [511:0] hdr, input logic [15:0] id, input int nb, input int dest,
                          input logic [1:0] ch, input int gap_at, input int rdy_mode, output int cycles);
    exp_t e;
    cycles = 0;
    case (dest)
      0: e_data++;
      1: e_ctrl++;
      2: e_drop++;
      default: begin e_drop++; e_auth++; end
    endcase
    for (int b = 0; b < nb; b++) begin
      logic acc;
      int   w;
      s_axis_tdata  = (b == 0) ? hdr : {448'h0, 32'hDA7A0000, id, 16'(b)};
      s_axis_tuser  = {96'h0, id, 16'(b)};
      s_axis_tlast  = (b == nb - 1);
      s_axis_tvalid = 1'b1;
      acc = 1'b0;
      w = 0;
      while (!acc && w < 100) begin
        @(negedge clk);
        if (rdy_mode == 1) check("rdy_track", s_axis_tready, !m_axis_tvalid || m_axis_tready);
        if (rdy_mode == 2) check("drop_rdy", s_axis_tready, 1'b1);
        acc = s_axis_tready;
        @(posedge clk);
        #1;
        cycles++;
        w++;
      end
      check("beat_accepted", acc, 1'b1);
      e.d = s_axis_tdata; e.u = s_axis_tuser; e.l = s_axis_tlast; e.ch = ch;
      if (dest == 0) mq.push_back(e);
      if (dest == 1) cq.push_back(e);
      if (b == gap_at) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m_axis_tvalid && m_axis_tready) begin
      if (mq.size() == 0) check("m_unexp_vld", m_axis_tvalid, 1'b0);
      else begin
        e = mq.pop_front();
        check("m_tdata", m_axis_tdata, e.d);
        check("m_tuser", m_axis_tuser, e.u);
        check("m_tlast", m_axis_tlast, e.l);
        check("m_tkeep", m_axis_tkeep, {64{1'b1}});
      end
    end
    if (c_m_axis_tvalid && c_m_axis_tready) begin
      if (cq.size() == 0) check("c_unexp_vld", c_m_axis_tvalid, 1'b0);
      else begin
        e = cq.pop_front();
        check("c_tdata", c_m_axis_tdata, e.d);
        check("c_tuser", c_m_axis_tuser, e.u);
        check("c_tlast", c_m_axis_tlast, e.l);
        check("c_chan", c_m_axis_chan, e.ch);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [31:0] CK = 32'hA5A55A5A;

  initial begin
    logic [511:0] h;
    logic [3:0]   pat;
    int           cyc;
    aresetn = 1'b0;
    time_stamp = 96'h1000;
    cookie_val = CK;
    s_axis_tdata = '0; s_axis_tkeep = '1; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; c_m_axis_tready = 1'b1;
    pat = 4'b1001;

    #12;
    check("rst_s_rdy", s_axis_tready, 1'b0);
    check("rst_m_vld", m_axis_tvalid, 1'b0);
    check("rst_c_vld", c_m_axis_tvalid, 1'b0);
    check("rst_m_data", m_axis_tdata, 512'h0);
    check("rst_token", ctrl_token, 32'h0);
    check("rst_chan", c_m_axis_chan, 2'd0);
    check_stats("rst");
    @(posedge clk); #1;
    aresetn = 1'b1;
    idle(2);

    // Plain UDP data packet
    h = mk_hdr(16'h0008, 8'h11, 16'h1234, CK, 32'h0, 16'd1);
    send_pkt(h, 16'd1, 3, 0, 2'd0, -1, 0, cyc);
    @(negedge clk);
    check("t1_lat_vld", m_axis_tvalid, 1'b1);
    check("t1_lat_last", m_axis_tlast, 1'b1);
    check("t1_c_vld", c_m_axis_tvalid, 1'b0);
    idle(2);
    check_stats("t1");

    // Authenticated control packet on port index 2; token rekeys to time_stamp
    h = mk_hdr(16'h0008, 8'h11, 16'hf3f1, CK, 32'h0, 16'd2);
    send_pkt(h, 16'd2, 3, 1, 2'd2, -1, 0, cyc);
    idle(2);
    check("t2_token", ctrl_token, 32'h00001000);
    time_stamp = 96'h2000;
    check_stats("t2");

    // Replay with stale token is dropped as an auth failure
    send_pkt(h, 16'd3, 2, 3, 2'd0, -1, 0, cyc);
    idle(2);
    check("t3_m_vld", m_axis_tvalid, 1'b0);
    check("t3_c_vld", c_m_axis_tvalid, 1'b0);
    check("t3_token", ctrl_token, 32'h00001000);
    check_stats("t3");

    // Non-IPv4 packet drains at one beat per cycle even with data output stalled
    m_axis_tready = 1'b0;
    h = mk_hdr(16'h0608, 8'h11, 16'h1234, CK, 32'h0, 16'd4);
    send_pkt(h, 16'd4, 4, 2, 2'd0, -1, 2, cyc);
    check("t4_cycles", cyc, 4);
    idle(1);
    @(negedge clk);
    check("t4_m_vld", m_axis_tvalid, 1'b0);
    check("t4_c_vld", c_m_axis_tvalid, 1'b0);
    @(posedge clk); #1;
    m_axis_tready = 1'b1;

    // Data packet against a stuttering data-path ready
    h = mk_hdr(16'h0008, 8'h11, 16'h1234, CK, 32'h0, 16'd5);
    fork
      send_pkt(h, 16'd5, 5, 0, 2'd0, -1, 1, cyc);
      begin
        for (int k = 0; k < 24; k++) begin
          m_axis_tready = pat[k % 4];
          @(posedge clk); #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    idle(3);
    check("t5_mq_empty", mq.size(), 0);
    check_stats("t5");

    // Reset during beat 2 of a 4-beat data packet
    h = mk_hdr(16'h0008, 8'h11, 16'h1234, CK, 32'h0, 16'd6);
    s_axis_tdata = h; s_axis_tuser = {96'h0, 16'd6, 16'd0}; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("t6_b1_rdy", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    s_axis_tdata = {448'h0, 32'hDA7A0000, 16'd6, 16'd1};
    aresetn = 1'b0;
    #2;
    check("t6_rst_m_vld", m_axis_tvalid, 1'b0);
    check("t6_rst_m_data", m_axis_tdata, 512'h0);
    check("t6_rst_c_vld", c_m_axis_tvalid, 1'b0);
    check("t6_rst_s_rdy", s_axis_tready, 1'b0);
    check("t6_rst_token", ctrl_token, 32'h0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    e_data = 0; e_ctrl = 0; e_drop = 0; e_auth = 0;
    mq.delete();
    cq.delete();
    // Remaining beats (payload, not an IPv4 header) classify as a fresh, dropped packet
    send_pkt({448'h0, 32'hDA7A0000, 16'd6, 16'd2}, 16'd6, 2, 2, 2'd0, -1, 2, cyc);
    idle(2);
    check("t6_m_vld", m_axis_tvalid, 1'b0);
    check("t6_c_vld", c_m_axis_tvalid, 1'b0);
    check_stats("t6");

    // Back-to-back: data, control (with a tvalid gap), rekeyed control, wrong cookie
    time_stamp = 96'h3000;
    h = mk_hdr(16'h0008, 8'h11, 16'h1234, CK, 32'h0, 16'd7);
    send_pkt(h, 16'd7, 3, 0, 2'd0, -1, 0, cyc);
    h = mk_hdr(16'h0008, 8'h11, 16'hf1f1, CK, 32'h0, 16'd8);
    send_pkt(h, 16'd8, 3, 1, 2'd0, 1, 0, cyc);
    h = mk_hdr(16'h0008, 8'h11, 16'hf4f1, CK, 32'h3000, 16'd9);
    send_pkt(h, 16'd9, 2, 1, 2'd3, -1, 0, cyc);
    h = mk_hdr(16'h0008, 8'h11, 16'hf2f1, 32'h12345678, 32'h3000, 16'd10);
    send_pkt(h, 16'd10, 1, 3, 2'd0, -1, 0, cyc);
    idle(4);
    check("t7_token", ctrl_token, 32'h00003000);
    check("t7_mq_empty", mq.size(), 0);
    check("t7_cq_empty", cq.size(), 0);
    check_stats("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
